music_play_ctrl: RTL and testbench

//  Playback sequencer for the music player; sits between keyboard control and the tone ROM / speaker datapath.

---
 rtl/music_ctrl_pkg.sv | 52 +++++
 rtl/music_play_ctrl_beat_divider.sv | 38 +++
 rtl/music_play_ctrl.sv | 151 +++++++++++++++
 tb/tb_music_play_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_ctrl_pkg.sv
// Shared types for the music player sequencer: FSM state encoding and
// key-priority indices (lower index = higher priority).
package music_ctrl_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int NUM_KEYS  = 6;
    localparam int KEY_ESC   = 0;
    localparam int KEY_ENTER = 1;
    localparam int KEY_FF    = 2;
    localparam int KEY_BF    = 3;
    localparam int KEY_UP    = 4;
    localparam int KEY_DOWN  = 5;

    function automatic logic [NUM_KEYS-1:0] legal_keys(input state_e s);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        case (s)
            MENU: begin
                m[KEY_ENTER] = 1'b1;
                m[KEY_UP]    = 1'b1;
                m[KEY_DOWN]  = 1'b1;
            end
            PLAY, PAUSE: begin
                m[KEY_ESC]   = 1'b1;
                m[KEY_ENTER] = 1'b1;
                m[KEY_FF]    = 1'b1;
                m[KEY_BF]    = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // One-hot of the lowest set index, i.e. the highest-priority key.
    function automatic logic [NUM_KEYS-1:0] pick_key(input logic [NUM_KEYS-1:0] k);
        logic [NUM_KEYS-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (k[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/music_play_ctrl_beat_divider.sv
// Beat timebase: counts 0..BEAT_DIV-1 while enabled; tc_o flags the terminal
// cycle. Clear dominates enable. Shared with the tone generator.
module beat_divider #(
    parameter int BEAT_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int               CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/music_play_ctrl.sv
// Playback sequencer: MENU/PLAY/PAUSE FSM, song select and beat address.
// Define AUTO_NEXT_EN to roll into the next song at song end instead of returning to MENU.
module music_play_ctrl
    import music_ctrl_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int SONG_LEN  = 512,
    parameter int SEEK_STEP = 32,
    parameter int BEAT_DIV  = 12_500_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic                         key_enter,
    input  logic                         key_esc,
    input  logic                         key_ff,
    input  logic                         key_bf,
    output logic [$clog2(NUM_SONGS)-1:0] song_sel,
    output logic [$clog2(SONG_LEN)-1:0]  beat_addr,
    output logic                         playing,
    output logic                         in_menu,
    output logic                         beat_tick,
    output logic                         song_end
);

    localparam int                SEL_W      = $clog2(NUM_SONGS);
    localparam int                ADDR_W     = $clog2(SONG_LEN);
    localparam logic [SEL_W-1:0]  SEL_LAST   = SEL_W'(NUM_SONGS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W:0]   ADDR_LAST_X = (ADDR_W + 1)'(SONG_LEN - 1);
    localparam logic [ADDR_W:0]   STEP_X     = (ADDR_W + 1)'(SEEK_STEP);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d, sel_inc;
    logic [ADDR_W-1:0]   addr_q, addr_d, ff_addr, bf_addr;
    logic                tick_q, tick_d, end_q, end_d;
    logic                playing_q, in_menu_q;
    logic [NUM_KEYS-1:0] keys, act;
    logic                div_en, div_clr, div_tc;
    logic [ADDR_W:0]     addr_x, ff_sum, bf_diff;

    assign keys[KEY_ESC]   = key_esc;
    assign keys[KEY_ENTER] = key_enter;
    assign keys[KEY_FF]    = key_ff;
    assign keys[KEY_BF]    = key_bf;
    assign keys[KEY_UP]    = key_up;
    assign keys[KEY_DOWN]  = key_down;
    assign act = pick_key(keys & legal_keys(state_q));

    // Any acted key in PLAY stalls the divider: enter holds it, seek/esc clear it,
    // so a seek coinciding with terminal count never produces a tick.
    assign div_en = (state_q == PLAY) && (act == '0);

    beat_divider #(
        .BEAT_DIV(BEAT_DIV)
    ) u_beat_divider (
        .clk  (clk),
        .rst  (rst),
        .en_i (div_en),
        .clr_i(div_clr),
        .tc_o (div_tc)
    );

    // Seek in ADDR_W+1 bits; the top bit of the difference is the borrow.
    assign addr_x  = {1'b0, addr_q};
    assign ff_sum  = addr_x + STEP_X;
    assign bf_diff = addr_x - STEP_X;
    assign ff_addr = (ff_sum > ADDR_LAST_X) ? ADDR_LAST : ff_sum[ADDR_W-1:0];
    assign bf_addr = bf_diff[ADDR_W] ? '0 : bf_diff[ADDR_W-1:0];
    assign sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        tick_d  = 1'b0;
        end_d   = 1'b0;
        div_clr = 1'b0;
        case (state_q)
            MENU: begin
                if (act[KEY_ENTER]) begin
                    addr_d  = '0;
                    div_clr = 1'b1;
                    state_d = PLAY;
                end else if (act[KEY_UP]) begin
                    sel_d = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
                end else if (act[KEY_DOWN]) begin
                    sel_d = sel_inc;
                end
            end
            PLAY, PAUSE: begin
                if (act[KEY_ESC]) begin
                    state_d = MENU;
                    addr_d  = '0;
                    div_clr = 1'b1;
                end else if (act[KEY_ENTER]) begin
                    state_d = (state_q == PLAY) ? PAUSE : PLAY;
                end else if (act[KEY_FF]) begin
                    addr_d  = ff_addr;
                    div_clr = 1'b1;
                end else if (act[KEY_BF]) begin
                    addr_d  = bf_addr;
                    div_clr = 1'b1;
                end else if (div_tc) begin
                    tick_d = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        end_d  = 1'b1;
                        addr_d = '0;
`ifdef AUTO_NEXT_EN
                        sel_d  = sel_inc;
`else
                        state_d = MENU;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = MENU;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MENU;
            sel_q     <= '0;
            addr_q    <= '0;
            tick_q    <= 1'b0;
            end_q     <= 1'b0;
            playing_q <= 1'b0;
            in_menu_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            tick_q    <= tick_d;
            end_q     <= end_d;
            playing_q <= (state_d == PLAY);
            in_menu_q <= (state_d == MENU);
        end
    end

    assign song_sel  = sel_q;
    assign beat_addr = addr_q;
    assign playing   = playing_q;
    assign in_menu   = in_menu_q;
    assign beat_tick = tick_q;
    assign song_end  = end_q;

endmodule

// File: tb/tb_music_play_ctrl.sv
// Self-checking bench for music_play_ctrl (small parameters); expected beat
// addresses are queued ahead of each tick and consumed as ticks appear.
module tb_music_play_ctrl;

    localparam int NUM_SONGS = 4;
    localparam int SONG_LEN  = 16;
    localparam int SEEK_STEP = 5;
    localparam int BEAT_DIV  = 4;

    localparam logic [5:0] K_ESC   = 6'b000001;
    localparam logic [5:0] K_ENTER = 6'b000010;
    localparam logic [5:0] K_FF    = 6'b000100;
    localparam logic [5:0] K_BF    = 6'b001000;
    localparam logic [5:0] K_UP    = 6'b010000;
    localparam logic [5:0] K_DOWN  = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0;
    logic       key_esc = 1'b0, key_ff = 1'b0, key_bf = 1'b0;
    logic [1:0] song_sel;
    logic [3:0] beat_addr;
    logic       playing, in_menu, beat_tick, song_end;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [3:0] sb_q[$];

    music_play_ctrl #(
        .NUM_SONGS(NUM_SONGS),
        .SONG_LEN (SONG_LEN),
        .SEEK_STEP(SEEK_STEP),
        .BEAT_DIV (BEAT_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_up   (key_up),
        .key_down (key_down),
        .key_enter(key_enter),
        .key_esc  (key_esc),
        .key_ff   (key_ff),
        .key_bf   (key_bf),
        .song_sel (song_sel),
        .beat_addr(beat_addr),
        .playing  (playing),
        .in_menu  (in_menu),
        .beat_tick(beat_tick),
        .song_end (song_end)
    );

    always #5 clk = ~clk;

    // Advance one clock, then consume a scoreboard entry for any tick seen.
    task automatic step();
        logic [3:0] exp_addr;
        @(posedge clk);
        #1;
        if (beat_tick === 1'b1) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_tick: tick at beat_addr=%0d, expected no tick", beat_addr);
            end else begin
                exp_addr = sb_q.pop_front();
                if (beat_addr !== exp_addr)
                    $display("FAIL sb_tick: beat_addr=%0d expected %0d", beat_addr, exp_addr);
                else begin
                    pass_cnt++;
                    $display("tick beat_addr=%0d", beat_addr);
                end
            end
        end
    endtask

    task automatic pulse(input logic [5:0] k);
        {key_down, key_up, key_bf, key_ff, key_enter, key_esc} = k;
        step();
        {key_down, key_up, key_bf, key_ff, key_enter, key_esc} = 6'b0;
        $display("keys=%06b -> sel=%0d addr=%0d playing=%0b in_menu=%0b", k, song_sel, beat_addr, playing, in_menu);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (song_sel !== 2'd0) $display("FAIL rst_sel: got %0d expected 0", song_sel); else pass_cnt++;
        total_cnt++; if (beat_addr !== 4'd0) $display("FAIL rst_addr: got %0d expected 0", beat_addr); else pass_cnt++;
        total_cnt++; if (playing !== 1'b0) $display("FAIL rst_playing: got %0b expected 0", playing); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL rst_in_menu: got %0b expected 1", in_menu); else pass_cnt++;
        total_cnt++; if (beat_tick !== 1'b0) $display("FAIL rst_tick: got %0b expected 0", beat_tick); else pass_cnt++;
        total_cnt++; if (song_end !== 1'b0) $display("FAIL rst_end: got %0b expected 0", song_end); else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_menu_nav();
        pulse(K_UP);
        total_cnt++; if (song_sel !== 2'd3) $display("FAIL menu_up_wrap: got %0d expected 3", song_sel); else pass_cnt++;
        total_cnt++; if (playing !== 1'b0) $display("FAIL menu_playing: got %0b expected 0", playing); else pass_cnt++;
        pulse(K_DOWN);
        total_cnt++; if (song_sel !== 2'd0) $display("FAIL menu_down_wrap: got %0d expected 0", song_sel); else pass_cnt++;
        pulse(K_UP | K_DOWN);
        total_cnt++; if (song_sel !== 2'd3) $display("FAIL menu_up_over_down: got %0d expected 3", song_sel); else pass_cnt++;
        pulse(K_ESC | K_FF | K_BF | K_DOWN);
        total_cnt++; if (song_sel !== 2'd0) $display("FAIL menu_illegal_keys: got %0d expected 0", song_sel); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL menu_stay: got %0b expected 1", in_menu); else pass_cnt++;
        pulse(K_DOWN);
        total_cnt++; if (song_sel !== 2'd1) $display("FAIL menu_down: got %0d expected 1", song_sel); else pass_cnt++;
    endtask

    task automatic test_play();
        pulse(K_ENTER);
        total_cnt++; if (playing !== 1'b1) $display("FAIL play_start: playing=%0b expected 1", playing); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b0) $display("FAIL play_in_menu: got %0b expected 0", in_menu); else pass_cnt++;
        total_cnt++; if (beat_addr !== 4'd0) $display("FAIL play_addr0: got %0d expected 0", beat_addr); else pass_cnt++;
        for (int b = 1; b <= 13; b++) begin
            sb_q.push_back(4'(b));
            repeat (3) step();
            total_cnt++; if (beat_tick !== 1'b0) $display("FAIL play_early_tick: beat %0d tick=%0b expected 0", b, beat_tick); else pass_cnt++;
            step();
            total_cnt++; if (beat_tick !== 1'b1) $display("FAIL play_tick: beat %0d tick=%0b expected 1", b, beat_tick); else pass_cnt++;
        end
        total_cnt++; if (beat_addr !== 4'd13) $display("FAIL play_addr13: got %0d expected 13", beat_addr); else pass_cnt++;
    endtask

    task automatic test_seek();
        logic [3:0] bf_exp[4];
        bf_exp = '{4'd10, 4'd5, 4'd0, 4'd0};
        pulse(K_FF);
        total_cnt++; if (beat_addr !== 4'd15) $display("FAIL ff_clamp: got %0d expected 15", beat_addr); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            pulse(K_BF);
            total_cnt++; if (beat_addr !== bf_exp[i]) $display("FAIL bf_%0d: got %0d expected %0d", i, beat_addr, bf_exp[i]); else pass_cnt++;
        end
        repeat (3) step();
        pulse(K_FF);
        total_cnt++; if (beat_addr !== 4'd5) $display("FAIL ff_at_tc: got %0d expected 5", beat_addr); else pass_cnt++;
        total_cnt++; if (beat_tick !== 1'b0) $display("FAIL ff_at_tc_tick: got %0b expected 0", beat_tick); else pass_cnt++;
        sb_q.push_back(4'd6);
        repeat (3) step();
        total_cnt++; if (beat_tick !== 1'b0) $display("FAIL seek_clear_early: got %0b expected 0", beat_tick); else pass_cnt++;
        step();
        total_cnt++; if (beat_tick !== 1'b1) $display("FAIL seek_clear_tick: got %0b expected 1", beat_tick); else pass_cnt++;
    endtask

    task automatic test_pause();
        repeat (2) step();
        pulse(K_ENTER);
        total_cnt++; if (playing !== 1'b0) $display("FAIL pause_playing: got %0b expected 0", playing); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b0) $display("FAIL pause_in_menu: got %0b expected 0", in_menu); else pass_cnt++;
        repeat (20) step();
        total_cnt++; if (beat_addr !== 4'd6) $display("FAIL pause_frozen: got %0d expected 6", beat_addr); else pass_cnt++;
        pulse(K_ENTER);
        total_cnt++; if (playing !== 1'b1) $display("FAIL resume_playing: got %0b expected 1", playing); else pass_cnt++;
        sb_q.push_back(4'd7);
        step();
        total_cnt++; if (beat_tick !== 1'b0) $display("FAIL resume_early: got %0b expected 0", beat_tick); else pass_cnt++;
        step();
        total_cnt++; if (beat_tick !== 1'b1) $display("FAIL resume_tick: got %0b expected 1", beat_tick); else pass_cnt++;
        pulse(K_ENTER);
        pulse(K_FF);
        total_cnt++; if (beat_addr !== 4'd12) $display("FAIL pause_ff: got %0d expected 12", beat_addr); else pass_cnt++;
        total_cnt++; if (playing !== 1'b0) $display("FAIL pause_ff_state: playing=%0b expected 0", playing); else pass_cnt++;
        pulse(K_BF | K_UP);
        total_cnt++; if (beat_addr !== 4'd7) $display("FAIL pause_bf: got %0d expected 7", beat_addr); else pass_cnt++;
        total_cnt++; if (song_sel !== 2'd1) $display("FAIL pause_up_ignored: got %0d expected 1", song_sel); else pass_cnt++;
        pulse(K_ENTER);
    endtask

    task automatic test_song_end();
        for (int b = 8; b <= 15; b++) begin
            sb_q.push_back(4'(b));
            repeat (4) step();
        end
        total_cnt++; if (beat_addr !== 4'd15) $display("FAIL end_last_beat: got %0d expected 15", beat_addr); else pass_cnt++;
        sb_q.push_back(4'd0);
        repeat (3) step();
        total_cnt++; if (song_end !== 1'b0) $display("FAIL end_early: got %0b expected 0", song_end); else pass_cnt++;
        step();
        total_cnt++; if (song_end !== 1'b1) $display("FAIL end_pulse: got %0b expected 1", song_end); else pass_cnt++;
        total_cnt++; if (beat_addr !== 4'd0) $display("FAIL end_addr: got %0d expected 0", beat_addr); else pass_cnt++;
`ifdef AUTO_NEXT_EN
        total_cnt++; if (song_sel !== 2'd2) $display("FAIL end_next_sel: got %0d expected 2", song_sel); else pass_cnt++;
        total_cnt++; if (playing !== 1'b1) $display("FAIL end_keep_playing: got %0b expected 1", playing); else pass_cnt++;
`else
        total_cnt++; if (song_sel !== 2'd1) $display("FAIL end_keep_sel: got %0d expected 1", song_sel); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL end_to_menu: got %0b expected 1", in_menu); else pass_cnt++;
`endif
        step();
        total_cnt++; if (song_end !== 1'b0) $display("FAIL end_one_cycle: got %0b expected 0", song_end); else pass_cnt++;
    endtask

    task automatic test_multi_key();
`ifndef AUTO_NEXT_EN
        pulse(K_ENTER);
`endif
        pulse(K_FF);
        total_cnt++; if (beat_addr !== 4'd5) $display("FAIL multi_pre_ff: got %0d expected 5", beat_addr); else pass_cnt++;
        pulse(K_ESC | K_FF | K_ENTER);
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL multi_esc_menu: got %0b expected 1", in_menu); else pass_cnt++;
        total_cnt++; if (playing !== 1'b0) $display("FAIL multi_esc_playing: got %0b expected 0", playing); else pass_cnt++;
        total_cnt++; if (beat_addr !== 4'd0) $display("FAIL multi_esc_addr: got %0d expected 0", beat_addr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        pulse(K_DOWN);
        pulse(K_ENTER);
        sb_q.push_back(4'd1);
        repeat (4) step();
        total_cnt++; if (beat_addr !== 4'd1) $display("FAIL mid_pre_addr: got %0d expected 1", beat_addr); else pass_cnt++;
        repeat (2) step();
        #3 rst = 1'b1;
        #1;
        total_cnt++; if (song_sel !== 2'd0) $display("FAIL arst_sel: got %0d expected 0", song_sel); else pass_cnt++;
        total_cnt++; if (beat_addr !== 4'd0) $display("FAIL arst_addr: got %0d expected 0", beat_addr); else pass_cnt++;
        total_cnt++; if (playing !== 1'b0) $display("FAIL arst_playing: got %0b expected 0", playing); else pass_cnt++;
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL arst_in_menu: got %0b expected 1", in_menu); else pass_cnt++;
        total_cnt++; if (beat_tick !== 1'b0) $display("FAIL arst_tick: got %0b expected 0", beat_tick); else pass_cnt++;
        total_cnt++; if (song_end !== 1'b0) $display("FAIL arst_end: got %0b expected 0", song_end); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        total_cnt++; if (in_menu !== 1'b1) $display("FAIL post_rst_menu: got %0b expected 1", in_menu); else pass_cnt++;
        total_cnt++; if (song_end !== 1'b0) $display("FAIL post_rst_end: got %0b expected 0", song_end); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_menu_nav();
        test_play();
        test_seek();
        test_pause();
        test_song_end();
        test_multi_key();
        test_reset_mid();
        total_cnt++; if (sb_q.size() != 0) $display("FAIL sb_drain: %0d ticks outstanding, expected 0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
